// File: rtl/dmem_arbiter_if.sv
// Bundle of per-core request/response signals and the shared data-RAM port.
// The arbiter uses the slave view; cores plus memory (or a bench) use the master view.
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

interface dmem_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = `DATA_ADDR_W,
  parameter int DATA_W  = `DATA_W
);
  logic [N_CORES-1:0]        req;
  logic [N_CORES-1:0]        we;
  logic [N_CORES*ADDR_W-1:0] addr;
  logic [N_CORES*DATA_W-1:0] wdata;
  logic [N_CORES-1:0]        stall;
  logic [N_CORES-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output stall, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  stall, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM among N_CORES cores.
// One access in flight at a time: IDLE grants, BUSY waits MEM_LAT, DONE pulses rvalid.
`ifndef DATA_ADDR_W
`define DATA_ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module dmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = `DATA_ADDR_W,
  parameter int DATA_W  = `DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  // Bit b of the result is set at every position k whose index has bit b set.
  function automatic logic [N_CORES-1:0] idx_bit_mask(input int b);
    logic [N_CORES-1:0] m;
    m = '0;
    for (int k = 0; k < N_CORES; k++) begin
      m = m | (N_CORES'((k >> b) & 1) << k);
    end
    return m;
  endfunction

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_g;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_wr;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [N_CORES-1:0]  r_rvalid;

  logic [ADDR_W-1:0]   w_addr_arr  [N_CORES];
  logic [DATA_W-1:0]   w_wdata_arr [N_CORES];
  logic [2*N_CORES-1:0] w_req_dbl;
  logic [N_CORES-1:0]  w_req_rot;
  logic [N_CORES-1:0]  w_low;
  logic [PTR_W-1:0]    w_off;
  logic [PTR_W:0]      w_sum;
  logic [PTR_W-1:0]    w_g;
  logic [PTR_W-1:0]    w_g_inc;
  logic [N_CORES-1:0]  w_g_onehot;

  // Rotate requests so that position 0 is the core at rr_ptr, then take the lowest set bit.
  assign w_req_dbl = {bus.req, bus.req};
  assign w_req_rot = N_CORES'(w_req_dbl >> r_rr_ptr);

  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
      localparam logic [N_CORES-1:0] LOWER = N_CORES'((1 << gi) - 1);
      assign w_addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
      assign w_low[gi]       = w_req_rot[gi] & ~(|(w_req_rot & LOWER));
      assign w_g_onehot[gi]  = (r_g == PTR_W'(gi));
    end
    for (genvar gi = 0; gi < PTR_W; gi++) begin : g_enc
      assign w_off[gi] = |(w_low & idx_bit_mask(gi));
    end
  endgenerate

  assign w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_g     = (w_sum >= (PTR_W+1)'(N_CORES)) ? PTR_W'(w_sum - (PTR_W+1)'(N_CORES))
                                                  : PTR_W'(w_sum);
  assign w_g_inc = (r_g == PTR_W'(N_CORES - 1)) ? '0 : r_g + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_g         <= '0;
      r_cnt       <= '0;
      r_is_wr     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_rvalid    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.req) begin
            r_g         <= w_g;
            r_is_wr     <= bus.we[w_g];
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.we[w_g];
            r_mem_addr  <= w_addr_arr[w_g];
            r_mem_wdata <= w_wdata_arr[w_g];
            r_cnt       <= CNT_W'(MEM_LAT);
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          // Completion does not depend on req[g]: a flushed access still finishes.
          if (r_cnt == '0) begin
            if (!r_is_wr) begin
              r_rdata <= bus.mem_rdata;
            end
            r_rvalid <= w_g_onehot;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_rvalid <= '0;
          r_rr_ptr <= w_g_inc;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stall     = bus.req & ~r_rvalid;
  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = r_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
